// File: rtl/battleship_game_ctrl_if.sv
// Button inputs and board/cursor/state outputs of the battleship game controller.
interface battleship_game_ctrl_if #(
  parameter int N = 5
) ();
  logic                     btn_up;
  logic                     btn_down;
  logic                     btn_left;
  logic                     btn_right;
  logic                     btn_fire;
  logic [2:0]               i_actual;
  logic [2:0]               j_actual;
  logic [N-1:0][N-1:0][1:0] tablero_jugador;
  logic [N-1:0][N-1:0][1:0] tablero_pc;
  logic [2:0]               game_state;

  // Button source side (testbench / debouncer) and display/readback consumer.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_fire,
    input  i_actual, j_actual, tablero_jugador, tablero_pc, game_state
  );

  // Game controller side.
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_fire,
    output i_actual, j_actual, tablero_jugador, tablero_pc, game_state
  );
endinterface

// File: rtl/battleship_game_ctrl.sv
// Battleship game controller: owns both 5x5 boards, the cursor, the turn
// timer and the PLACE/PLAYER/PC/WIN/LOSE state machine. The PC opponent
// draws shot candidates from an 8-bit Fibonacci LFSR.
// Cell encoding: 00 water, 01 ship, 10 miss, 11 hit (bit1 = already shot).
module battleship_game_ctrl #(
  parameter int             N            = 5,
  parameter int             SHIP_CELLS   = 5,
  parameter logic [N*N-1:0] PC_SHIP_MASK = 25'h000_001F,
  parameter int             TURN_TIMEOUT = 250_000_000,
  parameter logic [7:0]     LFSR_SEED    = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  battleship_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_PLACE  = 3'd0,
    ST_PLAYER = 3'd1,
    ST_PC     = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4
  } state_e;

  localparam int             TW      = $clog2(TURN_TIMEOUT) + 1;
  localparam logic [TW-1:0]  T_LAST  = TW'(TURN_TIMEOUT - 1);
  localparam logic [2:0]     MAX_IDX = 3'(N - 1);
  localparam logic [2:0]     N_IDX   = 3'(N);
  localparam logic [2:0]     SC      = 3'(SHIP_CELLS);

  state_e                   state_q, state_d;
  logic [2:0]               i_q, i_d, j_q, j_d;
  logic [N-1:0][N-1:0][1:0] jug_q, jug_d;
  logic [N-1:0][N-1:0][1:0] pc_q, pc_d;
  logic [2:0]               placed_q, placed_d;
  logic [2:0]               phits_q, phits_d;
  logic [2:0]               pchits_q, pchits_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [7:0]               lfsr_q, lfsr_d;

  logic [2:0] cand_r, cand_c;
  logic       move_ok;

  // Next-state logic: cursor, LFSR, board updates and turn sequencing.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    jug_d    = jug_q;
    pc_d     = pc_q;
    placed_d = placed_q;
    phits_d  = phits_q;
    pchits_d = pchits_q;
    timer_d  = '0;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cand_r   = lfsr_q[2:0];
    cand_c   = lfsr_q[5:3];

    // Fire always acts on the pre-move cursor, so a fire cycle never moves.
    move_ok = (state_q == ST_PLACE || state_q == ST_PLAYER) && !bus.btn_fire;
    if (move_ok) begin
      if (bus.btn_up) begin
        if (i_q != 3'd0) i_d = i_q - 3'd1;
      end else if (bus.btn_down) begin
        if (i_q != MAX_IDX) i_d = i_q + 3'd1;
      end else if (bus.btn_left) begin
        if (j_q != 3'd0) j_d = j_q - 3'd1;
      end else if (bus.btn_right) begin
        if (j_q != MAX_IDX) j_d = j_q + 3'd1;
      end
    end

    unique case (state_q)
      ST_PLACE: begin
        if (bus.btn_fire && jug_q[i_q][j_q] == 2'b00) begin
          jug_d[i_q][j_q] = 2'b01;
          placed_d        = placed_q + 3'd1;
          if (placed_d == SC) state_d = ST_PLAYER;
        end
      end
      ST_PLAYER: begin
        // A valid shot on the last timer cycle takes precedence over timeout.
        if (bus.btn_fire && !pc_q[i_q][j_q][1]) begin
          pc_d[i_q][j_q] = {1'b1, pc_q[i_q][j_q][0]};
          if (pc_q[i_q][j_q][0]) phits_d = phits_q + 3'd1;
          state_d = (phits_d == SC) ? ST_WIN : ST_PC;
        end else if (timer_q == T_LAST) begin
          state_d = ST_PC;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_PC: begin
        // Out-of-range or already-shot candidates simply retry next cycle.
        if (cand_r < N_IDX && cand_c < N_IDX) begin
          if (!jug_q[cand_r][cand_c][1]) begin
            jug_d[cand_r][cand_c] = {1'b1, jug_q[cand_r][cand_c][0]};
            if (jug_q[cand_r][cand_c][0]) pchits_d = pchits_q + 3'd1;
            state_d = (pchits_d == SC) ? ST_LOSE : ST_PLAYER;
          end
        end
      end
      default: ; // WIN / LOSE are terminal
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_PLACE;
      i_q      <= '0;
      j_q      <= '0;
      jug_q    <= '0;
      placed_q <= '0;
      phits_q  <= '0;
      pchits_q <= '0;
      timer_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          pc_q[r][c] <= {1'b0, PC_SHIP_MASK[r*N+c]};
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      jug_q    <= jug_d;
      pc_q     <= pc_d;
      placed_q <= placed_d;
      phits_q  <= phits_d;
      pchits_q <= pchits_d;
      timer_q  <= timer_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign bus.i_actual        = i_q;
  assign bus.j_actual        = j_q;
  assign bus.tablero_jugador = jug_q;
  assign bus.tablero_pc      = pc_q;
  assign bus.game_state      = state_q;

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Scoreboard bench for battleship_game_ctrl: the driver applies one input
// vector per cycle, advances a game-rule model and queues the expected
// outputs; a monitor pops and compares after every rising edge.
module tb_battleship_game_ctrl;
  localparam int          N    = 5;
  localparam int          SC   = 2;
  localparam int          TO   = 8;
  localparam logic [24:0] MASK = 25'h3;
  localparam logic [7:0]  SEED = 8'hA5;

  localparam int PLACE = 0, PLAYER = 1, PC = 2, WIN = 3, LOSE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  battleship_game_ctrl_if #(.N(N)) bus ();

  battleship_game_ctrl #(
    .N(N), .SHIP_CELLS(SC), .PC_SHIP_MASK(MASK),
    .TURN_TIMEOUT(TO), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [2:0]  i;
    logic [2:0]  j;
    logic [49:0] pj;
    logic [49:0] pp;
    logic [2:0]  st;
  } snap_t;

  snap_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Game-rule model state
  int m_st, m_i, m_j, m_placed, m_ph, m_pch, m_turn, m_tick;
  int pb[N][N];
  int cb[N][N];
  logic [7:0] lseq[255];

  task automatic chk(input string nm, input logic [49:0] act, input logic [49:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = PLACE; m_i = 0; m_j = 0;
    m_placed = 0; m_ph = 0; m_pch = 0; m_turn = 0; m_tick = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        pb[r][c] = 0;
        cb[r][c] = MASK[r*N+c] ? 1 : 0;
      end
  endtask

  task automatic model_move(input bit up, input bit dn, input bit lf, input bit rt);
    if (up)      m_i = (m_i > 0) ? m_i - 1 : 0;
    else if (dn) m_i = (m_i < N-1) ? m_i + 1 : N-1;
    else if (lf) m_j = (m_j > 0) ? m_j - 1 : 0;
    else if (rt) m_j = (m_j < N-1) ? m_j + 1 : N-1;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit lf, input bit rt,
                            input bit fire, input bit rst);
    int l, r, c;
    if (rst) begin
      model_reset();
      return;
    end
    l = int'(lseq[m_tick % 255]);
    m_tick++;
    case (m_st)
      PLACE: begin
        if (fire) begin
          if (pb[m_i][m_j] == 0) begin
            pb[m_i][m_j] = 1;
            m_placed++;
            if (m_placed == SC) begin m_st = PLAYER; m_turn = 0; end
          end
        end else model_move(up, dn, lf, rt);
      end
      PLAYER: begin
        if (fire && cb[m_i][m_j] < 2) begin
          cb[m_i][m_j] += 2;
          if (cb[m_i][m_j] == 3) m_ph++;
          m_st = (m_ph == SC) ? WIN : PC;
        end else begin
          if (!fire) model_move(up, dn, lf, rt);
          if (m_turn == TO - 1) m_st = PC;
          else m_turn++;
        end
      end
      PC: begin
        r = l % 8;
        c = (l / 8) % 8;
        if (r < N && c < N && pb[r][c] < 2) begin
          pb[r][c] += 2;
          if (pb[r][c] == 3) m_pch++;
          m_st  = (m_pch == SC) ? LOSE : PLAYER;
          m_turn = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic snap_t snapshot();
    snap_t s;
    s.i  = 3'(m_i);
    s.j  = 3'(m_j);
    s.st = 3'(m_st);
    s.pj = '0;
    s.pp = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s.pj[(r*N+c)*2 +: 2] = 2'(pb[r][c]);
        s.pp[(r*N+c)*2 +: 2] = 2'(cb[r][c]);
      end
    return s;
  endfunction

  task automatic step(input bit up, input bit dn, input bit lf, input bit rt,
                      input bit fire, input bit rst);
    @(negedge clk);
    bus.btn_up    = up;
    bus.btn_down  = dn;
    bus.btn_left  = lf;
    bus.btn_right = rt;
    bus.btn_fire  = fire;
    rst_n         = !rst;
    model_step(up, dn, lf, rt, fire, rst);
    expq.push_back(snapshot());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_step(input int rst_odds);
    step($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
         $urandom_range(3) == 0, $urandom_range(2) == 0,
         rst_odds > 0 && $urandom_range(rst_odds - 1) == 0);
  endtask

  // Idle while the model sits in state s; an expired bound is a failure.
  task automatic wait_leave(input int s, input int bound, input string nm);
    int k = 0;
    while (m_st == s && k < bound) begin
      idle();
      k++;
    end
    n_cmp++;
    if (m_st == s) begin
      n_bad++;
      $display("FAIL %s: still in state %0d after %0d cycles, required exit", nm, s, bound);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation after each edge.
  always @(posedge clk) begin
    snap_t e;
    logic [49:0] pj, pp;
    #1;
    if (expq.size() > 0) begin
      e  = expq.pop_front();
      pj = bus.tablero_jugador;
      pp = bus.tablero_pc;
      chk("i_actual", 50'(bus.i_actual), 50'(e.i));
      chk("j_actual", 50'(bus.j_actual), 50'(e.j));
      chk("game_state", 50'(bus.game_state), 50'(e.st));
      chk("tablero_jugador", pj, e.pj);
      chk("tablero_pc", pp, e.pp);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lseq[0] = SEED;
    for (int k = 1; k < 255; k++)
      lseq[k] = {lseq[k-1][6:0], lseq[k-1][7] ^ lseq[k-1][5] ^ lseq[k-1][4] ^ lseq[k-1][3]};
    model_reset();
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0; bus.btn_fire = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Cursor clamping and priority
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (6) step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);

    // Placement: duplicate fire ignored, second placement enters PLAYER
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);

    // Player miss, then PC turn
    step(0, 0, 0, 0, 1, 0);
    wait_leave(PC, 600, "pc_turn_1");

    // Idle timeout hands turn to PC
    wait_leave(PLAYER, 20, "timeout");
    wait_leave(PC, 600, "pc_turn_2");

    // Two hits on the PC ships -> WIN, then frozen
    repeat (4) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    wait_leave(PC, 600, "pc_turn_3");
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (20) rnd_step(0);

    // PC sinks both player ships -> LOSE, then reset
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    begin
      int k = 0;
      while (m_st != LOSE && k < 12000) begin
        idle();
        k++;
      end
      n_cmp++;
      if (m_st != LOSE) begin
        n_bad++;
        $display("FAIL reach_lose: model state %0d, required %0d", m_st, LOSE);
      end
    end
    repeat (5) rnd_step(0);
    step(0, 0, 0, 0, 0, 1);
    idle();

    // Random games with occasional mid-game reset
    for (int g = 0; g < 6; g++) begin
      step(0, 0, 0, 0, 0, 1);
      repeat (400) rnd_step(150);
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
